// File: rtl/sad_pkg.sv
// Shared types and widths for the SAD control block.
// State encoding matches the datapath debug view.
package sad_pkg;

    localparam int LAT_W  = 3;
    localparam int ITER_W = 9;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

endpackage

// File: rtl/sad_lat_timer.sv
// Loadable down-counter that times the memory read latency.
// expire is high while the count sits at 1 (last wait cycle).
module sad_lat_timer
    import sad_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [LAT_W-1:0] load_val,
    input  logic             en,
    output logic             expire
);

    logic [LAT_W-1:0] cnt_q;
    logic [LAT_W-1:0] cnt_d;

    // load wins over decrement; hold at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == LAT_W'(1));

endmodule

// File: rtl/sad_ctrl.sv
// Control FSM for the SAD datapath: clears, per-element loads,
// memory latency wait, abort and iteration watchdog.
module sad_ctrl
    import sad_pkg::*;
#(
    parameter int MEM_LAT  = 1,
    parameter int MAX_ITER = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic abort,
    input  logic i_lt_256,
    output logic i_inc,
    output logic i_clr,
    output logic sum_ld,
    output logic sum_clr,
    output logic sadreg_ld,
    output logic sadreg_clr,
    output logic busy,
    output logic done,
    output logic err
);

    localparam logic [LAT_W-1:0]  LAT_V    = LAT_W'(MEM_LAT);
    localparam logic [ITER_W-1:0] ITER_MAX = ITER_W'(MAX_ITER);
    localparam bit                HAS_LAT  = (MEM_LAT > 0);

    state_t              state_q, state_d;
    logic [ITER_W-1:0]   iter_q, iter_d;
    logic                err_q, err_d;
    logic                tmr_load;
    logic                tmr_en;
    logic                tmr_expire;

    sad_lat_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (LAT_V),
        .en       (tmr_en),
        .expire   (tmr_expire)
    );

    // next state and control decode; abort overrides at the end
    always_comb begin
        state_d    = state_q;
        iter_d     = iter_q;
        err_d      = err_q;
        tmr_load   = 1'b0;
        tmr_en     = 1'b0;
        i_inc      = 1'b0;
        i_clr      = 1'b0;
        sum_ld     = 1'b0;
        sum_clr    = 1'b0;
        sadreg_ld  = 1'b0;
        sadreg_clr = 1'b0;
        done       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_INIT;
                    err_d   = 1'b0;
                end
            end
            S_INIT: begin
                i_clr      = 1'b1;
                sum_clr    = 1'b1;
                sadreg_clr = 1'b1;
                tmr_load   = 1'b1;
                iter_d     = '0;
                state_d    = HAS_LAT ? S_WAIT : S_CHECK;
            end
            S_WAIT: begin
                tmr_en = 1'b1;
                if (tmr_expire) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!i_lt_256) begin
                    sadreg_ld = 1'b1;
                    state_d   = S_DONE;
                end else if (iter_q < ITER_MAX) begin
                    sum_ld   = 1'b1;
                    i_inc    = 1'b1;
                    iter_d   = iter_q + 1'b1;
                    tmr_load = 1'b1;
                    state_d  = HAS_LAT ? S_WAIT : S_CHECK;
                end else begin
                    err_d   = 1'b1;
                    state_d = S_ERR;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            S_ERR: begin
                i_clr   = 1'b1;
                sum_clr = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (abort && (state_q == S_INIT || state_q == S_WAIT ||
                      state_q == S_CHECK)) begin
            i_clr     = 1'b1;
            sum_clr   = 1'b1;
            sum_ld    = 1'b0;
            i_inc     = 1'b0;
            sadreg_ld = 1'b0;
            tmr_load  = 1'b0;
            tmr_en    = 1'b0;
            iter_d    = iter_q;
            err_d     = err_q;
            state_d   = S_IDLE;
        end
    end

    // state, watchdog count and sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            iter_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            err_q   <= err_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign err  = err_q;

endmodule

// File: tb/tb_sad_ctrl.sv
// Directed bench for sad_ctrl: three instances cover latency 1,
// latency 0 and a small watchdog limit.
module tb_sad_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic st_a = 1'b0, ab_a = 1'b0, lt_a;
    logic inc_a, clr_a, sld_a, sclr_a, rld_a, rclr_a;
    logic busy_a, done_a, err_a;

    logic st_b = 1'b0, ab_b = 1'b0, lt_b;
    logic inc_b, clr_b, sld_b, sclr_b, rld_b, rclr_b;
    logic busy_b, done_b, err_b;

    logic st_c = 1'b0, ab_c = 1'b0, lt_c = 1'b1;
    logic inc_c, clr_c, sld_c, sclr_c, rld_c, rclr_c;
    logic busy_c, done_c, err_c;

    logic [8:0] addr_a, addr_b;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sad_ctrl #(.MEM_LAT(1), .MAX_ITER(256)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(st_a), .abort(ab_a),
        .i_lt_256(lt_a), .i_inc(inc_a), .i_clr(clr_a),
        .sum_ld(sld_a), .sum_clr(sclr_a), .sadreg_ld(rld_a),
        .sadreg_clr(rclr_a), .busy(busy_a), .done(done_a),
        .err(err_a)
    );

    sad_ctrl #(.MEM_LAT(0), .MAX_ITER(256)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(st_b), .abort(ab_b),
        .i_lt_256(lt_b), .i_inc(inc_b), .i_clr(clr_b),
        .sum_ld(sld_b), .sum_clr(sclr_b), .sadreg_ld(rld_b),
        .sadreg_clr(rclr_b), .busy(busy_b), .done(done_b),
        .err(err_b)
    );

    sad_ctrl #(.MEM_LAT(1), .MAX_ITER(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(st_c), .abort(ab_c),
        .i_lt_256(lt_c), .i_inc(inc_c), .i_clr(clr_c),
        .sum_ld(sld_c), .sum_clr(sclr_c), .sadreg_ld(rld_c),
        .sadreg_clr(rclr_c), .busy(busy_c), .done(done_c),
        .err(err_c)
    );

    // address counter model of the datapath, low at address 7
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) addr_a <= '0;
        else if (clr_a) addr_a <= '0;
        else if (inc_a) addr_a <= addr_a + 1'b1;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) addr_b <= '0;
        else if (clr_b) addr_b <= '0;
        else if (inc_b) addr_b <= addr_b + 1'b1;
    end

    assign lt_a = (addr_a < 9'd7);
    assign lt_b = (addr_b < 9'd7);

    task automatic check_eq(input string tag,
                            input logic [31:0] got,
                            input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // expected {busy,done,rld,sld,inc,clr,sclr,rclr} for a run
    // started at cycle 0 with n loads and latency ml
    function automatic logic [7:0] exp_run(int c, int ml, int n);
        int  d;
        int  k;
        bit  ck;
        logic b, dn, rl, sl, cl;
        d  = 2 + (n + 1) * (ml + 1);
        ck = (c >= 2 + ml) && (((c - 2 - ml) % (ml + 1)) == 0);
        k  = ck ? (c - 2 - ml) / (ml + 1) : 0;
        b  = (c >= 1) && (c <= d);
        dn = (c == d);
        rl = ck && (k == n);
        sl = ck && (k < n);
        cl = (c == 1);
        return {b, dn, rl, sl, sl, cl, cl, cl};
    endfunction

    initial begin
        logic [7:0] ev;
        int inits;
        int dones;

        #1;
        check_eq("rst_a", {26'd0, busy_a, done_a, err_a, sld_a,
                 clr_a, rld_a}, 32'd0);
        check_eq("rst_c", {29'd0, busy_c, err_c, sclr_c}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // latency 1, seven elements
        step();
        st_a = 1'b1;
        for (int c = 0; c <= 20; c++) begin
            if (c == 1) st_a = 1'b0;
            #1;
            ev = exp_run(c, 1, 7);
            check_eq($sformatf("ml1_c%0d", c),
                     {24'd0, busy_a, done_a, rld_a, sld_a, inc_a,
                      clr_a, sclr_a, rclr_a}, {24'd0, ev});
            step();
        end

        // latency 0, seven elements
        st_b = 1'b1;
        for (int c = 0; c <= 12; c++) begin
            if (c == 1) st_b = 1'b0;
            #1;
            ev = exp_run(c, 0, 7);
            check_eq($sformatf("ml0_c%0d", c),
                     {24'd0, busy_b, done_b, rld_b, sld_b, inc_b,
                      clr_b, sclr_b, rclr_b}, {24'd0, ev});
            step();
        end

        // watchdog with limit 4 and loop condition stuck high
        st_c = 1'b1;
        for (int c = 0; c <= 14; c++) begin
            logic b, cl, sl, e;
            if (c == 1) st_c = 1'b0;
            #1;
            b  = (c >= 1) && (c <= 12);
            cl = (c == 1) || (c == 12);
            sl = (c == 3) || (c == 5) || (c == 7) || (c == 9);
            e  = (c >= 12);
            check_eq($sformatf("wd_c%0d", c),
                     {26'd0, busy_c, done_c, sl_or(sld_c, inc_c),
                      clr_c, sclr_c, err_c},
                     {26'd0, b, 1'b0, sl, cl, cl, e});
            step();
        end
        st_c = 1'b1;
        #1;
        check_eq("wd_err_hold", {31'd0, err_c}, 32'd1);
        step();
        st_c = 1'b0;
        #1;
        check_eq("wd_restart", {30'd0, busy_c, err_c}, 32'd2);
        repeat (14) step();
        check_eq("wd_err_again", {30'd0, busy_c, err_c}, 32'd1);

        // abort in the third WAIT cycle
        st_a = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            if (c == 1) st_a = 1'b0;
            ab_a = (c == 6);
            #1;
            if (c == 5)
                check_eq("ab_pre", {31'd0, sld_a}, 32'd1);
            if (c == 6)
                check_eq("ab_cyc",
                         {27'd0, clr_a, sclr_a, sld_a, inc_a, rld_a},
                         {27'd0, 5'b11000});
            if (c >= 7)
                check_eq($sformatf("ab_post%0d", c),
                         {29'd0, busy_a, done_a, rld_a}, 32'd0);
            step();
        end

        // asynchronous reset while sum_ld is high
        st_a = 1'b1;
        for (int c = 0; c <= 3; c++) begin
            if (c == 1) st_a = 1'b0;
            if (c < 3) step();
        end
        #1;
        check_eq("rs_pre", {31'd0, sld_a}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("rs_async", {30'd0, sld_a, busy_a}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_eq("rs_after", {29'd0, busy_a, err_a, err_c}, 32'd0);

        // start held through DONE: one extra run from cycle 19
        st_a = 1'b1;
        inits = 0;
        dones = 0;
        for (int c = 0; c <= 45; c++) begin
            if (c == 20) st_a = 1'b0;
            #1;
            if (c <= 18) begin
                ev = exp_run(c, 1, 7);
                check_eq($sformatf("hold_c%0d", c),
                         {30'd0, busy_a, done_a},
                         {30'd0, ev[7], ev[6]});
            end
            if (c == 19)
                check_eq("hold_idle", {31'd0, busy_a}, 32'd0);
            if (c == 20)
                check_eq("hold_init", {30'd0, busy_a, rclr_a},
                         32'd3);
            if (c >= 19 && rclr_a) inits++;
            if (c >= 19 && done_a) dones++;
            step();
        end
        check_eq("hold_inits", inits, 32'd1);
        check_eq("hold_dones", dones, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    // sum_ld and i_inc must pulse together; fold into one bit
    function automatic logic sl_or(logic s, logic i);
        return (s === i) ? s : 1'bx;
    endfunction

endmodule

// File: doc/sad_ctrl.md
Name: sad_ctrl

Overview:
- Control FSM sitting directly upstream of the SAD datapath.
- Sequences address clear/increment, sum clear/load and result register clear/load over a block of samples.
- Waits a programmable memory read latency per element, because a_data/b_data come from synchronous memories addressed by ab_addr.
- Provides a start/busy/done handshake to the processor side, a soft abort, and an iteration watchdog.

Parameters:
- MEM_LAT, 1, read latency in cycles from an ab_addr change to valid a_data/b_data; legal range 0..7.
- MAX_ITER, 256, maximum element loads per run before the watchdog trips; legal range 1..511.

Ports:
- clk  input  1  rising-edge clock shared with the datapath
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a run; sampled only in IDLE
- abort  input  1  cancel a run in progress; ignored in IDLE
- i_lt_256  input  1  datapath loop condition, 1 = more elements remain
- i_inc  output  1  advance ab_addr
- i_clr  output  1  clear ab_addr
- sum_ld  output  1  accumulate current |a-b| into the running sum
- sum_clr  output  1  clear the running sum
- sadreg_ld  output  1  load the final sum into the sad register
- sadreg_clr  output  1  clear the sad register
- busy  output  1  run in progress (any state except IDLE)
- done  output  1  one-cycle pulse; sad is valid in this cycle
- err  output  1  sticky watchdog flag, cleared by the next accepted start

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, lat_cnt=0, iter_cnt=0, err=0; all outputs 0.
- Control outputs are decoded combinationally from state, plus i_lt_256 in CHECK. The datapath registers their effect on the next edge.
- States: IDLE, INIT, WAIT, CHECK, DONE, ERR.
- IDLE: all outputs 0. start=1 -> INIT and clear err.
- INIT (1 cycle): assert i_clr, sum_clr, sadreg_clr; load lat_cnt=MEM_LAT and iter_cnt=0. -> WAIT if MEM_LAT>0, else -> CHECK.
- WAIT: decrement lat_cnt each cycle. When lat_cnt==1, -> CHECK. WAIT lasts exactly MEM_LAT cycles.
- CHECK with i_lt_256=1 and iter_cnt<MAX_ITER:
  - assert sum_ld and i_inc; iter_cnt++; reload lat_cnt=MEM_LAT;
  - -> WAIT if MEM_LAT>0, else stay in CHECK.
- CHECK with i_lt_256=0: assert sadreg_ld -> DONE.
- CHECK with i_lt_256=1 and iter_cnt==MAX_ITER: no loads; set err=1 -> ERR.
- DONE (1 cycle): done=1 -> IDLE. A start in this cycle is ignored.
- ERR (1 cycle): assert i_clr and sum_clr -> IDLE. done is not pulsed; err stays 1.
- Latency: with N CHECK visits that see i_lt_256=1, and start sampled at cycle 0:
  - done is high at cycle 2 + (N+1)*(MEM_LAT+1).
  - Example: MEM_LAT=1, N=7 gives done at cycle 18.
- abort=1 in INIT, WAIT or CHECK has priority over all other transitions:
  - assert i_clr and sum_clr that cycle, suppress sum_ld, i_inc and sadreg_ld, -> IDLE;
  - no done; err unchanged; sad keeps its cleared value.
- abort in DONE or ERR: ignored; the normal transition completes.
- start while busy: ignored; no queuing.
- Reset mid-run: immediate return to IDLE; outputs 0 asynchronously. The datapath registers are not cleared by this block in that case.
- iter_cnt is 9 bits and does not wrap, because MAX_ITER<=511. lat_cnt is 3 bits.

Decomposition:
- sad_pkg holds:
  - state encoding constants (3 bits: IDLE=0, INIT=1, WAIT=2, CHECK=3, DONE=4, ERR=5);
  - LAT_W=3 and ITER_W=9.
- One natural sub-module, sad_lat_timer: a loadable 3-bit down-counter with load, en and expire outputs, used for WAIT.
- The watchdog counter stays inline.

Test Plan:
- MEM_LAT=1, i_lt_256 driven from a model whose ab_addr goes 0..7 (low at 7), start pulse at cycle 0 -> sum_ld/i_inc pulse 7 times, sadreg_ld once at cycle 17, done=1 only at cycle 18, busy high cycles 1-18.
- MEM_LAT=0, same model -> sum_ld on 7 consecutive cycles 2-8, sadreg_ld at cycle 9, done at cycle 10.
- MAX_ITER=4, i_lt_256 stuck at 1 -> exactly 4 sum_ld pulses, err=1, no done, IDLE two cycles after the 5th CHECK; next start clears err.
- abort asserted in the 3rd WAIT cycle -> i_clr and sum_clr pulse that cycle, no sadreg_ld, no done, busy low the next cycle.
- rst_n dropped mid-CHECK while sum_ld=1 -> sum_ld falls without waiting for a clock edge; after release, state=IDLE, err=0.
- start held high through DONE -> exactly one new run starts, accepted in the IDLE cycle after DONE.
